test_vector_checker: RTL
========================

Name: test_vector_checker

Overview:
- Receiving end of the float test-vector stream. Accepts IEEE-754 single-precision elements one per handshake and packs them into a VLEN-wide vector.
- Checks each element against the team's fixed 11-entry float table, starting at table index START and wrapping 10 -> 0. This is the same sequence our vector generators emit.
- Reports pass/fail, mismatch count and the first bad slot; used as the self-checking sink in simulation benches.

Parameters:
- START, 0, first expected table index, legal range [0,10].
- VLEN, 4, number of 32-bit elements per vector, VLEN >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins (or restarts) collection of one vector.
- in_valid  in  1  element on in_data is valid.
- in_ready  out  1  checker accepts an element this cycle.
- in_data  in  32  float element (sign[31], exp[30:23], mant[22:0]).
- vec  out  32*VLEN  assembled vector; slot k at bits [32k +: 32].
- vec_valid  out  1  vec is complete and stable; held until next start.
- done  out  1  one-cycle pulse when a vector finishes.
- pass  out  1  1 if mismatch_cnt == 0; valid while vec_valid.
- mismatch_cnt  out  $clog2(VLEN+1)  mismatching elements in current vector.
- first_bad_idx  out  $clog2(VLEN) (min 1)  slot of first mismatch; 0 if none.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - vec, vec_valid, done, pass, mismatch_cnt, first_bad_idx = 0; in_ready = 0.
  - Internal table index = START, slot = 0.
  - Reset mid-collection discards partial data.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE:
  - in_ready = 0.
  - start -> COLLECT. On that edge: clear mismatch_cnt, first_bad_idx, vec_valid, pass, vec; set idx = START, slot = 0.
- COLLECT:
  - in_ready = !start.
  - Beat accepted when in_valid && in_ready. On acceptance:
    - vec[slot] <= in_data.
    - Compare in_data against table[idx].
    - On mismatch, increment mismatch_cnt; if this is the first mismatch, first_bad_idx <= slot.
    - idx <= (idx == 10) ? 0 : idx+1.
    - slot <= slot+1.
  - Accepting slot VLEN-1 -> REPORT.
  - in_valid low holds all state (no timeout).
- REPORT (one cycle):
  - done = 1; vec_valid <= 1; pass <= (final mismatch_cnt == 0).
  - Next state IDLE.
  - done asserts exactly one cycle after the last accepted beat.
- start during COLLECT or REPORT: restarts as from IDLE. The coincident beat is not accepted, because in_ready is low that cycle.
- Match rule (base):
  - Exact 32-bit equality, except +0.0 (0x00000000) and -0.0 (0x80000000) are equal.
  - Inf must match exactly.
  - Any NaN input is a mismatch (the table contains no NaN).
- Table values, idx 0..10:
  - 0x404CCCCC (3.2), 0x40866666 (4.2), 0x3F28F5C2 (0.66), 0x3F028F5C (0.51)
  - 0xBF000000 (-0.5), 0xC0CCCCCC (-6.4), 0x3E000000 (0.125), 0x41CCCCCC (25.6)
  - 0xBDCCCCCC (-0.1), 0x00000000 (0.0), 0x7F800000 (+inf)
- mismatch_cnt cannot overflow: its width covers VLEN.

Optional Feature:
- Macro: TVC_ULP_TOL_EN.
- Defined: an element also matches when the sign bits are equal, neither operand is NaN/inf, and |in_data[30:0] - table[idx][30:0]| <= 1. This tolerates a 1-ULP rounding difference from DUT arithmetic; the ±0 rule still applies.
- Undefined: base exact-match rule only; no subtractor is synthesised.

Decomposition:
- Shared package tvf_pkg holds:
  - FLOAT_W = 32, TABLE_LEN = 11.
  - The 11-entry expected-value constant array plus field-slice constants (SIGN_BIT, EXP_MSB/LSB, MANT_MSB/LSB).
  - FSM state typedef.
  - The generator side uses the same table constants.
- One sub-module, float_match: combinational (a, b) -> match. It implements the ±0 rule, NaN rejection, and the TVC_ULP_TOL_EN tolerance.

Test Plan:
1. START=0, VLEN=4; start, then feed 0x404CCCCC, 0x40866666, 0x3F28F5C2, 0x3F028F5C back-to-back -> done pulses 1 cycle after 4th beat; pass=1, mismatch_cnt=0; vec = {0x3F028F5C, 0x3F28F5C2, 0x40866666, 0x404CCCCC}.
2. START=9, VLEN=3; feed 0x80000000, 0x7F800000, 0x404CCCCC with in_valid gaps of 2 cycles -> wrap 10 -> 0 correct; -0 accepted; pass=1; in_ready high throughout COLLECT.
3. START=0, VLEN=4; slot 2 = 0x3F28F5C3 (+1 ULP), slot 3 = 0x7FC00000 (NaN) -> mismatch_cnt=2, first_bad_idx=2, pass=0. With TVC_ULP_TOL_EN: mismatch_cnt=1, first_bad_idx=3.
4. START=4, VLEN=4; after 2 correct beats (0xBF000000, 0xC0CCCCCC) drive start together with in_valid -> beat not accepted; counters cleared; next 4 beats compared from idx 4 again.
5. Drop rst_n for 1 cycle after 2 beats of a VLEN=4 collection -> all outputs 0 immediately (async); in_ready=0; no done pulse until a new start plus 4 beats.
6. After test 1 completes, hold in_valid high in IDLE for 5 cycles -> in_ready stays 0; vec/pass/vec_valid unchanged until next start.

Source files
------------

// File: rtl/tvf_pkg.sv
// Shared float test-vector definitions: expected-value table, float field slices and checker FSM states.
// The vector generators read the same table so both ends agree on the sequence.
package tvf_pkg;

    localparam int FLOAT_W   = 32;
    localparam int TABLE_LEN = 11;
    localparam int TBL_IDX_W = 4;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;

    localparam logic [FLOAT_W-1:0] FLOAT_TABLE [TABLE_LEN] = '{
        32'h404CCCCC,  // 3.2
        32'h40866666,  // 4.2
        32'h3F28F5C2,  // 0.66
        32'h3F028F5C,  // 0.51
        32'hBF000000,  // -0.5
        32'hC0CCCCCC,  // -6.4
        32'h3E000000,  // 0.125
        32'h41CCCCCC,  // 25.6
        32'hBDCCCCCC,  // -0.1
        32'h00000000,  // 0.0
        32'h7F800000   // +inf
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REPORT
    } tvc_state_e;

    function automatic logic [TBL_IDX_W-1:0] next_tbl_idx(input logic [TBL_IDX_W-1:0] idx);
        return (idx == TBL_IDX_W'(TABLE_LEN - 1)) ? '0 : idx + TBL_IDX_W'(1);
    endfunction

endpackage

// File: rtl/float_match.sv
// Combinational single-precision compare: +0/-0 equal, any NaN rejected.
// TVC_ULP_TOL_EN additionally accepts a 1-ULP magnitude difference between finite same-sign operands.
module float_match
    import tvf_pkg::*;
(
    input  logic [FLOAT_W-1:0] a,
    input  logic [FLOAT_W-1:0] b,
    output logic               match
);

    logic a_exp_max;
    logic b_exp_max;
    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic near;

    assign a_exp_max = &a[EXP_MSB:EXP_LSB];
    assign b_exp_max = &b[EXP_MSB:EXP_LSB];
    assign a_nan     = a_exp_max && (|a[MANT_MSB:MANT_LSB]);
    assign b_nan     = b_exp_max && (|b[MANT_MSB:MANT_LSB]);
    assign both_zero = (a[EXP_MSB:0] == '0) && (b[EXP_MSB:0] == '0);

`ifdef TVC_ULP_TOL_EN
    logic [EXP_MSB:0] mag_diff;

    // Magnitude bits of IEEE floats order like integers, so one ULP is an integer step of 1.
    assign mag_diff = (a[EXP_MSB:0] >= b[EXP_MSB:0]) ? a[EXP_MSB:0] - b[EXP_MSB:0]
                                                     : b[EXP_MSB:0] - a[EXP_MSB:0];
    assign near     = (a[SIGN_BIT] == b[SIGN_BIT]) && !a_exp_max && !b_exp_max
                      && (mag_diff[EXP_MSB:1] == '0);
`else
    assign near = 1'b0;
`endif

    assign match = !a_nan && !b_nan && ((a == b) || both_zero || near);

endmodule

// File: rtl/test_vector_checker.sv
// Sink for the float test-vector stream: packs VLEN elements, checks them against the shared table
// from index START (wrapping 10 -> 0) and reports pass, mismatch count and first bad slot. Optional: TVC_ULP_TOL_EN.
module test_vector_checker
    import tvf_pkg::*;
#(
    parameter  int START  = 0,
    parameter  int VLEN   = 4,
    localparam int CNT_W  = $clog2(VLEN + 1),
    localparam int SLOT_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FLOAT_W-1:0]      in_data,
    output logic [FLOAT_W*VLEN-1:0] vec,
    output logic                    vec_valid,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [SLOT_W-1:0]       first_bad_idx
);

    localparam logic [TBL_IDX_W-1:0] START_IDX = TBL_IDX_W'(START);
    localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(VLEN - 1);

    tvc_state_e                    state;
    logic [TBL_IDX_W-1:0]          idx;
    logic [SLOT_W-1:0]             slot;
    logic [VLEN-1:0][FLOAT_W-1:0]  vec_q;
    logic                          elem_match;
    logic                          accept;

    // NOTE: in_ready is combinational so a coincident start blocks that cycle's beat.
    assign in_ready = (state == ST_COLLECT) && !start;
    assign accept   = in_valid && in_ready;
    assign vec      = vec_q;

    float_match u_match (
        .a     (in_data),
        .b     (FLOAT_TABLE[idx]),
        .match (elem_match)
    );

    // NOTE: every register uses <= so all updates in this block see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= START_IDX;
            slot          <= '0;
            // NOTE: the vector store is reset too, since a reset must discard partial data visibly.
            vec_q         <= '0;
            vec_valid     <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            mismatch_cnt  <= '0;
            first_bad_idx <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state         <= ST_COLLECT;
                idx           <= START_IDX;
                slot          <= '0;
                vec_q         <= '0;
                vec_valid     <= 1'b0;
                pass          <= 1'b0;
                mismatch_cnt  <= '0;
                first_bad_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_COLLECT: begin
                        if (accept) begin
                            vec_q[slot] <= in_data;
                            if (!elem_match) begin
                                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                                if (mismatch_cnt == '0)
                                    first_bad_idx <= slot;
                            end
                            idx  <= next_tbl_idx(idx);
                            slot <= slot + SLOT_W'(1);
                            if (slot == LAST_SLOT) begin
                                state <= ST_REPORT;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_REPORT: begin
                        vec_valid <= 1'b1;
                        pass      <= (mismatch_cnt == '0);
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
